// File: rtl/wb_writer.sv
// Write-back stage: registers the MEM-stage result, selects ALU/load/link data and drives
// a single write pulse per instruction plus a same-cycle bypass and a retire counter.
module wb_writer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LINK_OFFSET = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic [1:0]        mem_wbsel,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [2:0]        mem_load_type,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic              wb_hold,
  input  logic              wb_flush,
  output logic              reg_write,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              align_err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  localparam logic [DATA_W-1:0] LINK_OFF_C = DATA_W'(LINK_OFFSET);

  // Little-endian lane extraction with sign/zero extension; reserved types yield zero.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0]        ltype,
                                                    input logic [1:0]        off);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = word[{off[1], 4'b0000} +: 16];
    byte_v = word[{off, 3'b000} +: 8];
    case (ltype)
      LT_LW:   load_extend = word;
      LT_LH:   load_extend = {{(DATA_W-16){half_v[15]}}, half_v};
      LT_LHU:  load_extend = {{(DATA_W-16){1'b0}}, half_v};
      LT_LB:   load_extend = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LT_LBU:  load_extend = {{(DATA_W-8){1'b0}}, byte_v};
      default: load_extend = {DATA_W{1'b0}};
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] ltype, input logic [1:0] off);
    case (ltype)
      LT_LW:          load_misaligned = (off != 2'b00);
      LT_LH, LT_LHU:  load_misaligned = off[0];
      LT_LB, LT_LBU:  load_misaligned = 1'b0;
      default:        load_misaligned = 1'b1;
    endcase
  endfunction

  logic              cap_valid_s;
  logic              cap_err_s;
  logic              cap_write_s;
  logic [DATA_W-1:0] cap_data_s;
  logic              reg_write_s;

  logic              valid_r;
  logic              write_r;
  logic              written_r;
  logic [ADDR_W-1:0] dst_r;
  logic [DATA_W-1:0] data_r;
  logic              align_err_r;
  logic [CNT_W-1:0]  retired_r;

  // Decode the incoming MEM entry so the WB entry holds ready-to-write data.
  always_comb begin
    cap_data_s = mem_alu_result;
    cap_err_s  = 1'b0;
    case (mem_wbsel)
      SEL_ALU: begin
        cap_data_s = mem_alu_result;
      end
      SEL_LOAD: begin
        cap_data_s = load_extend(mem_load_data, mem_load_type, mem_alu_result[1:0]);
        cap_err_s  = load_misaligned(mem_load_type, mem_alu_result[1:0]);
      end
      SEL_LINK: begin
        cap_data_s = mem_pc + LINK_OFF_C;
      end
      default: begin
        cap_data_s = mem_alu_result;
      end
    endcase
    cap_valid_s = mem_valid & ~wb_flush;
    cap_write_s = mem_regwrite & (mem_wbsel != 2'd3) & (mem_dst != {ADDR_W{1'b0}}) & ~cap_err_s;
  end

  // The written flag suppresses repeat pulses while a held entry sits in WB.
  assign reg_write_s = valid_r & write_r & ~written_r;

  // WB entry, sticky alignment error and retire counter; the counter bumps at capture
  // so it already reflects the instruction during its first WB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      write_r     <= 1'b0;
      written_r   <= 1'b0;
      dst_r       <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      align_err_r <= 1'b0;
      retired_r   <= {CNT_W{1'b0}};
    end else if (!wb_hold) begin
      valid_r     <= cap_valid_s;
      write_r     <= cap_write_s;
      written_r   <= 1'b0;
      dst_r       <= mem_dst;
      data_r      <= cap_data_s;
      align_err_r <= align_err_r | (cap_valid_s & cap_err_s);
      retired_r   <= retired_r + {{(CNT_W-1){1'b0}}, cap_valid_s};
    end else begin
      written_r   <= written_r | reg_write_s;
    end
  end

  assign reg_write = reg_write_s;
  assign wr_addr   = dst_r;
  assign wr_data   = data_r;
  assign fwd_valid = reg_write_s;
  assign fwd_addr  = dst_r;
  assign fwd_data  = data_r;
  assign align_err = align_err_r;
  assign retired   = retired_r;

endmodule
